// File: rtl/video_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_mode_ctrl
// Purpose  : Sequences the video mixer mode controls (scandoubler, scanlines,
//            hq2x). The host writes a shadow register. The shadow is applied
//            atomically on a VSync falling edge, so the mixer never changes
//            mode in the middle of a frame.
//            A scandoubler change alters the sync timing. After such a change
//            the block holds force_blank for SETTLE_FRAMES frames.
// Ports    : clk_sys     - master clock; all logic runs on its rising edge
//            reset_n     - asynchronous active-low reset
//            vsync       - positive VSync pulse, synchronous to clk_sys
//            cfg_wr      - write strobe, accepted while cfg_ready=1
//            cfg_data    - {hq2x, scandoubler, scanlines[1:0]}
//            cfg_ready   - shadow can accept a write
//            pending     - shadow holds an unapplied value
//            scandoubler - active setting to the mixer
//            scanlines   - active setting to the mixer
//            hq2x        - active setting to the mixer
//            force_blank - the mixer output must be blanked
//            vs_lost     - a VSync timeout fired since the last write
// Options  : `define VIDEO_MODE_TIMEOUT_EN to enable the lost-VSync timeout.
//            Without it, vs_lost is tied to 0 and PENDING waits for VSync
//            indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module video_mode_ctrl #(
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       cfg_wr,
  input  logic [3:0] cfg_data,
  output logic       cfg_ready,
  output logic       pending,
  output logic       scandoubler,
  output logic [1:0] scanlines,
  output logic       hq2x,
  output logic       force_blank,
  output logic       vs_lost
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_SETTLE  = 2'd2
  } state_t;

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_FRAMES);

  state_t     r_state;
  logic       r_old_vs;
  logic [3:0] r_shadow;
  logic [3:0] r_settle_cnt;

  logic       w_vse;
  logic       w_accept;
  logic       w_timeout;
  logic       w_event;
  logic [3:0] w_apply_cfg;

  assign w_vse    = r_old_vs & ~vsync;
  assign w_accept = cfg_wr & (r_state != S_SETTLE);

  // A write landing in the same cycle as the apply event takes priority over
  // the stored shadow, so the newest value is never lost.
  assign w_apply_cfg = cfg_wr ? cfg_data : r_shadow;

`ifdef VIDEO_MODE_TIMEOUT_EN
  localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] r_to_cnt;

  // The timeout counts cycles spent waiting in PENDING or SETTLE. A real VSync
  // edge restarts it, and so does an accepted write.
  assign w_timeout = (r_state != S_IDLE) && !w_vse && !w_accept &&
                     (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_vse || w_accept || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

  // A timeout behaves exactly like a VSync edge for sequencing purposes.
  assign w_event = w_vse | w_timeout;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_old_vs     <= 1'b0;
      r_shadow     <= 4'd0;
      r_settle_cnt <= 4'd0;
      cfg_ready    <= 1'b1;
      pending      <= 1'b0;
      scandoubler  <= 1'b0;
      scanlines    <= 2'd0;
      hq2x         <= 1'b0;
      force_blank  <= 1'b0;
      vs_lost      <= 1'b0;
    end else begin
      r_old_vs <= vsync;

      if (w_accept) begin
        vs_lost <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // A VSync edge in IDLE is deliberately ignored.
          if (cfg_wr) begin
            r_shadow <= cfg_data;
            pending  <= 1'b1;
            r_state  <= S_PENDING;
          end
        end

        S_PENDING: begin
          if (w_event) begin
            {hq2x, scandoubler, scanlines} <= w_apply_cfg;
            pending <= 1'b0;
            if (w_timeout) begin
              vs_lost <= 1'b1;
            end
            // A change in scandoubler alters the sync timing, so blank the
            // output until the downstream timing has settled.
            if (w_apply_cfg[2] != scandoubler) begin
              force_blank  <= 1'b1;
              cfg_ready    <= 1'b0;
              r_settle_cnt <= c_SETTLE_LOAD;
              r_state      <= S_SETTLE;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (cfg_wr) begin
            r_shadow <= cfg_data;
          end
        end

        S_SETTLE: begin
          // Writes are ignored here; cfg_ready is low.
          if (w_event) begin
            if (w_timeout) begin
              vs_lost <= 1'b1;
            end
            if (w_timeout || (r_settle_cnt <= 4'd1)) begin
              force_blank  <= 1'b0;
              cfg_ready    <= 1'b1;
              r_settle_cnt <= 4'd0;
              r_state      <= S_IDLE;
            end else begin
              r_settle_cnt <= r_settle_cnt - 4'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_mode_ctrl
// Purpose  : Self-checking bench for video_mode_ctrl. It runs directed
//            scenarios and a randomized run. Expected values come from a
//            frame-level model of the mode sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_mode_ctrl;

  localparam int SETTLE = 2;

  logic       clk_sys  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       vsync    = 1'b0;
  logic       cfg_wr   = 1'b0;
  logic [3:0] cfg_data = 4'd0;
  logic       cfg_ready;
  logic       pending;
  logic       scandoubler;
  logic [1:0] scanlines;
  logic       hq2x;
  logic       force_blank;
  logic       vs_lost;

  int total = 0;
  int bad   = 0;

  video_mode_ctrl #(
    .SETTLE_FRAMES (SETTLE),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .cfg_wr     (cfg_wr),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .pending    (pending),
    .scandoubler(scandoubler),
    .scanlines  (scanlines),
    .hq2x       (hq2x),
    .force_blank(force_blank),
    .vs_lost    (vs_lost)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model state: the applied config, an optional queued config,
  // and the number of blank frames still owed.
  logic [3:0] m_active;
  logic [3:0] m_shadow;
  bit         m_has_pend;
  int         m_blank_left;
  bit         m_prev_vs;

  function automatic logic [7:0] obs();
    return {scandoubler, scanlines, hq2x, force_blank, pending, cfg_ready, vs_lost};
  endfunction

  function automatic logic [7:0] expv();
    return {m_active[2], m_active[1:0], m_active[3], (m_blank_left > 0),
            m_has_pend, (m_blank_left == 0), 1'b0};
  endfunction

  task automatic model_reset();
    m_active     = 4'd0;
    m_shadow     = 4'd0;
    m_has_pend   = 1'b0;
    m_blank_left = 0;
    m_prev_vs    = 1'b0;
  endtask

  task automatic model_step(input bit wr, input logic [3:0] d, input bit vs);
    bit         fall;
    logic [3:0] nv;
    fall      = m_prev_vs && !vs;
    m_prev_vs = vs;
    if (m_blank_left > 0) begin
      if (fall) m_blank_left = m_blank_left - 1;
    end else if (m_has_pend && fall) begin
      nv = wr ? d : m_shadow;
      if (nv[2] != m_active[2]) m_blank_left = SETTLE;
      m_active   = nv;
      m_has_pend = 1'b0;
    end else if (wr) begin
      m_shadow   = d;
      m_has_pend = 1'b1;
    end
  endtask

  // Drive one clock cycle of inputs and advance the model with the same inputs.
  task automatic cyc(input bit wr, input logic [3:0] d, input bit vs);
    cfg_wr   = wr;
    cfg_data = d;
    vsync    = vs;
    @(posedge clk_sys);
    #1;
    model_step(wr, d, vs);
    cfg_wr = 1'b0;
  endtask

  // One VSync pulse. The falling edge is seen in the second cycle.
  task automatic vs_pulse();
    cyc(1'b0, 4'd0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    vsync    = 1'b0;
    cfg_wr   = 1'b0;
    cfg_data = 4'd0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs() !== 8'b0_00_0_0_0_1_0) begin
      $display("FAIL reset_values: got %b want %b", obs(), 8'b0_00_0_0_0_1_0);
      bad++;
    end
  endtask

  task automatic test_scanlines_apply();
    do_reset();
    cyc(1'b1, 4'b0010, 1'b0);
    total++;
    if (pending !== 1'b1) begin
      $display("FAIL write_latency: pending got %b want 1", pending);
      bad++;
    end
    cyc(1'b0, 4'd0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0);
    total++;
    if (scanlines !== 2'd2 || force_blank !== 1'b0 || cfg_ready !== 1'b1 ||
        obs() !== expv()) begin
      $display("FAIL scanlines_apply: got %b want %b (scanlines=2)", obs(), expv());
      bad++;
    end
  endtask

  task automatic test_sd_settle();
    do_reset();
    cyc(1'b1, 4'b0100, 1'b0);
    vs_pulse();
    total++;
    if (scandoubler !== 1'b1 || force_blank !== 1'b1 || cfg_ready !== 1'b0) begin
      $display("FAIL sd_apply: got %b want sd=1 blank=1 ready=0", obs());
      bad++;
    end
    vs_pulse();
    total++;
    if (force_blank !== 1'b1 || cfg_ready !== 1'b0 || obs() !== expv()) begin
      $display("FAIL settle_mid: got %b want %b", obs(), expv());
      bad++;
    end
    vs_pulse();
    total++;
    if (force_blank !== 1'b0 || cfg_ready !== 1'b1 || scandoubler !== 1'b1) begin
      $display("FAIL settle_end: got %b want sd=1 blank=0 ready=1", obs());
      bad++;
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0011, 1'b0);
    vs_pulse();
    total++;
    if (scanlines !== 2'd3 || obs() !== expv()) begin
      $display("FAIL latest_write_wins: got %b want %b", obs(), expv());
      bad++;
    end
  endtask

  task automatic test_coincident();
    do_reset();
    cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b0, 4'd0, 1'b1);
    cyc(1'b1, 4'b0010, 1'b0);
    total++;
    if (scanlines !== 2'd2 || pending !== 1'b0 || obs() !== expv()) begin
      $display("FAIL write_on_vse: got %b want %b", obs(), expv());
      bad++;
    end
    // A write equal to the active config still queues, then applies unblanked.
    cyc(1'b1, 4'b0010, 1'b0);
    total++;
    if (pending !== 1'b1) begin
      $display("FAIL same_cfg_pending: pending got %b want 1", pending);
      bad++;
    end
    vs_pulse();
    total++;
    if (obs() !== 8'b0_10_0_0_0_1_0) begin
      $display("FAIL same_cfg_apply: got %b want %b", obs(), 8'b0_10_0_0_0_1_0);
      bad++;
    end
  endtask

  task automatic test_write_in_settle();
    do_reset();
    cyc(1'b1, 4'b0100, 1'b0);
    vs_pulse();
    cyc(1'b1, 4'b1011, 1'b0);
    total++;
    if (pending !== 1'b0 || cfg_ready !== 1'b0) begin
      $display("FAIL settle_write_ignored: got %b want pending=0 ready=0", obs());
      bad++;
    end
    vs_pulse();
    vs_pulse();
    vs_pulse();
    total++;
    if (obs() !== 8'b1_00_0_0_0_1_0) begin
      $display("FAIL after_window: got %b want %b", obs(), 8'b1_00_0_0_0_1_0);
      bad++;
    end
  endtask

  task automatic test_reset_mid_settle();
    do_reset();
    cyc(1'b1, 4'b1111, 1'b0);
    vs_pulse();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (obs() !== 8'b0_00_0_0_0_1_0) begin
      $display("FAIL async_reset: got %b want %b", obs(), 8'b0_00_0_0_0_1_0);
      bad++;
    end
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit         wr;
      bit         vs;
      logic [3:0] d;
      wr = ($urandom_range(0, 3) == 0);
      vs = ($urandom_range(0, 4) == 0);
      d  = 4'($urandom);
      cyc(wr, d, vs);
      total++;
      if (obs() !== expv()) begin
        bad++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle %0d: got %b want %b", i, obs(), expv());
      end
    end
  endtask

`ifdef VIDEO_MODE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    cyc(1'b1, 4'b1000, 1'b0);
    for (int i = 0; i < 200 && hq2x !== 1'b1; i++) cyc(1'b0, 4'd0, 1'b0);
    total++;
    if (hq2x !== 1'b1 || vs_lost !== 1'b1 || force_blank !== 1'b0) begin
      $display("FAIL timeout_apply: got %b want hq2x=1 vs_lost=1 blank=0", obs());
      bad++;
    end
    cyc(1'b1, 4'b1000, 1'b0);
    total++;
    if (vs_lost !== 1'b0) begin
      $display("FAIL vs_lost_clear: got %b want 0", vs_lost);
      bad++;
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_scanlines_apply();
    test_sd_settle();
    test_overwrite();
    test_coincident();
    test_write_in_settle();
    test_reset_mid_settle();
    test_random();
`ifdef VIDEO_MODE_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
